pads_cfg_loader: RTL

Serial configuration front-end that drives the `cnfg_io`/`cnfg_en` write port of the pad output-enable register block. It collects a framed bitstream of per-pad values plus a per-pad write mask from a one-bit serial link, then commits the whole frame atomically as a single-cycle masked write. The block sits between the housekeeping serial master and the pad configuration register. Malformed frames are discarded and flagged; they never cause a partial write.

---
 rtl/pads_cfg_pkg.sv | 20 ++
 rtl/pads_cfg_if.sv | 16 +
 rtl/pads_cfg_shreg.sv | 44 ++++
 rtl/pads_cfg_loader.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pads_cfg_pkg.sv
// pads_cfg_pkg
//   Shared definitions for the pad configuration serial loader:
//   pad count, frame length, FSM state encoding and error codes.
package pads_cfg_pkg;

  localparam int NPADS   = 44;
  localparam int FRAME_W = 2 * NPADS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    APPLY = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;

endpackage

// File: rtl/pads_cfg_if.sv
// pads_cfg_if
//   One-bit serial link from the housekeeping serial master to the pad
//   configuration loader.
//   ser_data  : frame bit, taken when ser_valid & ser_ready
//   ser_valid : ser_data carries a frame bit this cycle
//   ser_load  : commit request for the collected frame
//   ser_ready : loader accepts ser_valid / ser_load
interface pads_cfg_if;
  logic ser_data;
  logic ser_valid;
  logic ser_load;
  logic ser_ready;

  modport master (output ser_data, ser_valid, ser_load, input  ser_ready);
  modport slave  (input  ser_data, ser_valid, ser_load, output ser_ready);
endinterface

// File: rtl/pads_cfg_shreg.sv
// pads_cfg_shreg
//   W-bit right-shift register: each new bit enters the MSB, so after W
//   shifts the first bit received sits in q[0].
//   clk, resetb : clock, asynchronous active-low reset
//   shift_en    : shift din in this cycle
//   clr         : synchronous clear (wins over shift_en)
//   din         : serial input bit
//   q           : register contents
module pads_cfg_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         shift_en,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (shift_en) begin
      sr_d = {din, sr_q[W-1:1]};
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/pads_cfg_loader.sv
// pads_cfg_loader
//   Collects a FRAME_W-bit serial frame (NPADS io values, then NPADS mask
//   bits, LSB first) and commits it as one single-cycle masked write.
//   Malformed frames are discarded and flagged, never partially written.
//   clk, resetb : clock, asynchronous active-low reset
//   ser         : serial link (slave side), ser_ready low only in APPLY
//   cnfg_io     : pad values of the last committed frame, held
//   cnfg_en     : pad write mask, non-zero for one cycle per commit
//   done        : one-cycle pulse alongside the cnfg_en cycle
//   err         : one-cycle pulse when a frame is discarded
//   err_code    : 01 short frame, 10 overflow; zero when err is low
//   fill_cnt    : bits collected in the current frame
module pads_cfg_loader #(
  parameter int NPADS   = pads_cfg_pkg::NPADS,
  parameter int FRAME_W = 2 * NPADS
) (
  input  logic                         clk,
  input  logic                         resetb,
  pads_cfg_if.slave                    ser,
  output logic [NPADS-1:0]             cnfg_io,
  output logic [NPADS-1:0]             cnfg_en,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [$clog2(FRAME_W+1)-1:0] fill_cnt
);

  import pads_cfg_pkg::*;

  localparam int CNT_W = $clog2(FRAME_W + 1);

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   fill_cnt_q,  fill_cnt_d;
  logic [NPADS-1:0]   cnfg_io_q,   cnfg_io_d;
  logic [NPADS-1:0]   cnfg_en_q,   cnfg_en_d;
  logic               done_q,      done_d;
  logic               err_q,       err_d;
  logic [1:0]         err_code_q,  err_code_d;
  logic               ser_ready_q, ser_ready_d;

  logic               shift_en;
  logic               sr_clr;
  logic [FRAME_W-1:0] sr;

  pads_cfg_shreg #(
    .W (FRAME_W)
  ) u_shreg (
    .clk      (clk),
    .resetb   (resetb),
    .shift_en (shift_en),
    .clr      (sr_clr),
    .din      (ser.ser_data),
    .q        (sr)
  );

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    cnfg_io_d  = cnfg_io_q;
    cnfg_en_d  = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;
    shift_en   = 1'b0;
    sr_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        // A bit wins over a load; a lone load is an empty (short) frame.
        if (ser.ser_valid) begin
          shift_en   = 1'b1;
          fill_cnt_d = CNT_W'(1);
          state_d    = SHIFT;
        end else if (ser.ser_load) begin
          err_d      = 1'b1;
          err_code_d = ERR_SHORT;
        end
      end

      SHIFT: begin
        // Load before the frame is complete: drop it, including any bit
        // presented in the same cycle.
        if (ser.ser_load) begin
          err_d      = 1'b1;
          err_code_d = ERR_SHORT;
          fill_cnt_d = '0;
          sr_clr     = 1'b1;
          state_d    = IDLE;
        end else if (ser.ser_valid) begin
          shift_en   = 1'b1;
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
          if (fill_cnt_q == CNT_W'(FRAME_W - 1)) begin
            state_d = FULL;
          end
        end
      end

      FULL: begin
        // An extra bit means the master lost framing: overflow wins over load.
        if (ser.ser_valid) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVF;
          fill_cnt_d = '0;
          sr_clr     = 1'b1;
          state_d    = IDLE;
        end else if (ser.ser_load) begin
          cnfg_io_d = sr[NPADS-1:0];
          cnfg_en_d = sr[FRAME_W-1:NPADS];
          done_d    = 1'b1;
          state_d   = APPLY;
        end
      end

      APPLY: begin
        // Write cycle; link inputs are ignored while ser_ready is low.
        fill_cnt_d = '0;
        sr_clr     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        fill_cnt_d = '0;
        sr_clr     = 1'b1;
        state_d    = IDLE;
      end
    endcase

    // ser_ready is registered, so it is derived from the state being entered.
    ser_ready_d = (state_d != APPLY);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      cnfg_io_q   <= '0;
      cnfg_en_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      ser_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      cnfg_io_q   <= cnfg_io_d;
      cnfg_en_q   <= cnfg_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      ser_ready_q <= ser_ready_d;
    end
  end

  assign ser.ser_ready = ser_ready_q;
  assign cnfg_io       = cnfg_io_q;
  assign cnfg_en       = cnfg_en_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign fill_cnt      = fill_cnt_q;

endmodule
